// File: rtl/pwm_capture.sv
// pwm_capture: measures an asynchronous PWM input and reports the high time and
// the period of the last complete cycle, in clock cycles. Also raises a level
// flag when the line is stuck high or stuck low for TIMEOUT cycles.
//
// Output semantics: fixed latency, no handshake. meas_valid is a single-cycle
// pulse; high_cnt/period_cnt change only in that cycle and hold otherwise, so a
// consumer samples them whenever meas_valid is 1. meas_valid rises
// SYNC_STAGES+1 cycles after the clock edge that first samples pwm_in high at
// the start of the next period.
module pwm_capture #(
  parameter int CNT_W       = 20,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 600000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] period_cnt,
  output logic             meas_valid,
  output logic             stuck_high,
  output logic             stuck_low
);

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_lvl;
  logic                   s_prev;
  logic                   rise_q;
  logic                   fall_q;
  logic [CNT_W-1:0]       per_ctr;
  logic [CNT_W-1:0]       hi_ctr;

  // Counters stop at TIMEOUT so a dead line can never wrap them back to a
  // plausible-looking value.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v >= TIMEOUT_C) ? TIMEOUT_C : v + ONE_C;
  endfunction

  assign s_lvl = sync_q[SYNC_STAGES-1];

  // Synchronizer chain bringing the asynchronous pwm_in into the clock domain.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
    end
  end

  // Registered rise/fall detection on the synchronized level.
  always_ff @(posedge clock) begin
    if (reset) begin
      s_prev <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      s_prev <= s_lvl;
      rise_q <= s_lvl & ~s_prev;
      fall_q <= ~s_lvl & s_prev;
    end
  end

  // Measurement FSM: counts high/period cycles, publishes on the rise that
  // closes a period, and handles the stuck-line timeouts.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      per_ctr    <= '0;
      hi_ctr     <= '0;
      high_cnt   <= '0;
      period_cnt <= '0;
      meas_valid <= 1'b0;
      stuck_high <= 1'b0;
      stuck_low  <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      if (!enable) begin
        // Results hold; everything else returns to a clean idle.
        state      <= ST_IDLE;
        per_ctr    <= '0;
        hi_ctr     <= '0;
        stuck_high <= 1'b0;
        stuck_low  <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (rise_q) begin
              // First rise only opens a measurement; nothing to publish yet.
              per_ctr    <= ONE_C;
              hi_ctr     <= ONE_C;
              stuck_high <= 1'b0;
              stuck_low  <= 1'b0;
              state      <= ST_HIGH;
            end else if (stuck_high) begin
              // Line still held high: low-time counting starts only after
              // the fall, so stuck_low cannot assert alongside stuck_high.
              per_ctr <= '0;
              if (fall_q) begin
                stuck_high <= 1'b0;
              end
            end else if (per_ctr == TIMEOUT_C) begin
              stuck_low <= 1'b1;
            end else begin
              per_ctr <= sat_inc(per_ctr);
            end
          end

          ST_HIGH: begin
            if (fall_q) begin
              per_ctr <= sat_inc(per_ctr);
              state   <= ST_LOW;
            end else if (hi_ctr == TIMEOUT_C) begin
              stuck_high <= 1'b1;
              per_ctr    <= '0;
              hi_ctr     <= '0;
              state      <= ST_IDLE;
            end else begin
              per_ctr <= sat_inc(per_ctr);
              hi_ctr  <= sat_inc(hi_ctr);
            end
          end

          ST_LOW: begin
            if (rise_q) begin
              // Rise beats a same-cycle timeout: the period is complete.
              period_cnt <= per_ctr;
              high_cnt   <= hi_ctr;
              meas_valid <= 1'b1;
              per_ctr    <= ONE_C;
              hi_ctr     <= ONE_C;
              state      <= ST_HIGH;
            end else if (per_ctr == TIMEOUT_C) begin
              stuck_low <= 1'b1;
              state     <= ST_IDLE;
            end else begin
              per_ctr <= sat_inc(per_ctr);
            end
          end

          default: begin
            state   <= ST_IDLE;
            per_ctr <= '0;
            hi_ctr  <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: directed scenarios with literal expectations plus a
// randomized phase, all compared every cycle against a timestamp-based model.
module tb_pwm_capture;

  localparam int CNT_W = 20;
  localparam int SYNC  = 2;
  localparam int TMO   = 64;
  localparam int LAT   = SYNC + 1;

  localparam int M_IDLE = 0;
  localparam int M_HIGH = 1;
  localparam int M_LOW  = 2;

  // ---------------- clock / reset / DUT ----------------
  logic             clock = 1'b0;
  logic             reset;
  logic             enable;
  logic             pwm_in;
  logic [CNT_W-1:0] high_cnt;
  logic [CNT_W-1:0] period_cnt;
  logic             meas_valid;
  logic             stuck_high;
  logic             stuck_low;

  always #5 clock = ~clock;

  pwm_capture #(
    .CNT_W(CNT_W),
    .SYNC_STAGES(SYNC),
    .TIMEOUT(TMO)
  ) dut (
    .clock(clock),
    .reset(reset),
    .enable(enable),
    .pwm_in(pwm_in),
    .high_cnt(high_cnt),
    .period_cnt(period_cnt),
    .meas_valid(meas_valid),
    .stuck_high(stuck_high),
    .stuck_low(stuck_low)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // ---------------- behavioural model ----------------
  // The measurement sees pwm_in delayed by SYNC+1 edges. Periods are computed
  // from the edge timestamps of rises and falls; timeouts from elapsed time.
  longint           cyc = 0;
  logic [SYNC+1:0]  hist = '0;
  int               mode = M_IDLE;
  longint           t_rise = 0;
  longint           t_fall = 0;
  longint           idle_since = 1;
  logic [CNT_W-1:0] e_hi = '0;
  logic [CNT_W-1:0] e_per = '0;
  logic             e_valid = 1'b0;
  logic             e_sh = 1'b0;
  logic             e_sl = 1'b0;
  logic [2*CNT_W-1:0] exp_q[$];

  // Model update on every active edge.
  always @(posedge clock) begin
    logic r;
    logic f;
    longint span;
    cyc++;
    if (reset) begin
      mode = M_IDLE; e_hi = '0; e_per = '0; e_valid = 1'b0;
      e_sh = 1'b0; e_sl = 1'b0; idle_since = cyc + 1; hist = '0;
    end else begin
      r = hist[SYNC] & ~hist[SYNC+1];
      f = ~hist[SYNC] & hist[SYNC+1];
      e_valid = 1'b0;
      if (!enable) begin
        mode = M_IDLE; e_sh = 1'b0; e_sl = 1'b0; idle_since = cyc + 1;
      end else if (mode == M_IDLE) begin
        if (r) begin
          mode = M_HIGH; t_rise = cyc; e_sh = 1'b0; e_sl = 1'b0;
        end else if (e_sh) begin
          if (f) begin e_sh = 1'b0; idle_since = cyc + 1; end
        end else if (cyc - idle_since >= TMO) begin
          e_sl = 1'b1;
        end
      end else if (mode == M_HIGH) begin
        if (f) begin
          mode = M_LOW; t_fall = cyc;
        end else if (cyc - t_rise >= TMO) begin
          e_sh = 1'b1; mode = M_IDLE;
        end
      end else begin
        if (r) begin
          span = (cyc - t_rise > TMO) ? TMO : cyc - t_rise;
          e_hi = CNT_W'(t_fall - t_rise);
          e_per = CNT_W'(span);
          e_valid = 1'b1;
          exp_q.push_back({e_hi, e_per});
          t_rise = cyc; mode = M_HIGH;
        end else if (cyc - t_rise >= TMO) begin
          e_sl = 1'b1; mode = M_IDLE;
        end
      end
      hist = {hist[SYNC:0], pwm_in};
    end
  end

  // ---------------- scoreboard / compare ----------------
  longint           pl_cyc[$];
  logic [CNT_W-1:0] pl_hi[$];
  logic [CNT_W-1:0] pl_per[$];
  longint           sl_first = -1;
  longint           sh_first = -1;

  always @(posedge clock) begin
    logic [2*CNT_W-1:0] pair;
    #2;
    n_vec++;
    if ({high_cnt, period_cnt, meas_valid, stuck_high, stuck_low} !==
        {e_hi, e_per, e_valid, e_sh, e_sl}) begin
      n_err++;
      $display("FAIL outputs cyc=%0d got hi=%0d per=%0d v=%b sh=%b sl=%b want hi=%0d per=%0d v=%b sh=%b sl=%b",
               cyc, high_cnt, period_cnt, meas_valid, stuck_high, stuck_low,
               e_hi, e_per, e_valid, e_sh, e_sl);
    end
    if (meas_valid === 1'b1) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL publish cyc=%0d got hi=%0d per=%0d want no publish", cyc, high_cnt, period_cnt);
      end else begin
        pair = exp_q.pop_front();
        if ({high_cnt, period_cnt} !== pair) begin
          n_err++;
          $display("FAIL publish cyc=%0d got hi=%0d per=%0d want hi=%0d per=%0d",
                   cyc, high_cnt, period_cnt, pair[2*CNT_W-1:CNT_W], pair[CNT_W-1:0]);
        end
      end
      pl_cyc.push_back(cyc);
      pl_hi.push_back(high_cnt);
      pl_per.push_back(period_cnt);
    end
    if (stuck_low === 1'b1 && sl_first < 0) sl_first = cyc;
    if (stuck_high === 1'b1 && sh_first < 0) sh_first = cyc;
  end

  task automatic chk(input string name, input longint act, input longint want);
    n_vec++;
    if (act != want) begin
      n_err++;
      $display("FAIL %s got=%0d want=%0d", name, act, want);
    end
  endtask

  task automatic clear_log();
    pl_cyc.delete(); pl_hi.delete(); pl_per.delete();
    sl_first = -1; sh_first = -1;
  endtask

  // ---------------- driver tasks ----------------
  longint rst_edge = 0;
  longint last_rise = 0;

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; pwm_in = 1'b0; enable = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    rst_edge = cyc;
    clear_log();
  endtask

  task automatic tick(input logic v);
    @(negedge clock);
    pwm_in = v;
  endtask

  task automatic wave(input int w, input int p);
    @(negedge clock);
    last_rise = cyc + 1;
    pwm_in = 1'b1;
    for (int i = 1; i < w; i++) tick(1'b1);
    for (int i = 0; i < p - w; i++) tick(1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    longint r5;
    longint rr;
    reset = 1'b1; enable = 1'b1; pwm_in = 1'b0;

    // 1. square wave W=3 P=10, five periods
    do_reset();
    chk("reset_high_cnt", high_cnt, 0);
    chk("reset_period_cnt", period_cnt, 0);
    for (int i = 0; i < 5; i++) wave(3, 10);
    repeat (5) tick(1'b0);
    chk("t1_pulses", pl_hi.size(), 4);
    for (int i = 0; i < pl_hi.size(); i++) begin
      chk("t1_high", pl_hi[i], 3);
      chk("t1_period", pl_per[i], 10);
      if (i > 0) chk("t1_spacing", pl_cyc[i] - pl_cyc[i-1], 10);
    end
    chk("t1_stuck_high", stuck_high, 0);
    chk("t1_stuck_low", stuck_low, 0);

    // 2. duty change 3 -> 7 at P=10, latency check
    do_reset();
    for (int i = 0; i < 3; i++) wave(3, 10);
    wave(7, 10);
    wave(7, 10);
    r5 = last_rise;
    repeat (5) tick(1'b0);
    chk("t2_pulses", pl_hi.size(), 4);
    if (pl_hi.size() == 4) begin
      chk("t2_old_high", pl_hi[2], 3);
      chk("t2_new_high", pl_hi[3], 7);
      chk("t2_new_period", pl_per[3], 10);
      chk("t2_latency", pl_cyc[3] - r5, LAT);
    end

    // 3. held low after reset -> stuck_low, cleared by a rise, then publish
    do_reset();
    repeat (70) tick(1'b0);
    chk("t3_stuck_low_time", sl_first, rst_edge + TMO + 1);
    wave(5, 20);
    chk("t3_stuck_low_cleared", stuck_low, 0);
    chk("t3_no_publish", pl_hi.size(), 0);
    wave(5, 20);
    repeat (4) tick(1'b0);
    chk("t3_one_publish", pl_hi.size(), 1);
    if (pl_hi.size() == 1) chk("t3_period", pl_per[0], 20);

    // 4. held high for 100 cycles -> stuck_high, fall clears it
    do_reset();
    repeat (3) tick(1'b0);
    @(negedge clock);
    rr = cyc + 1;
    pwm_in = 1'b1;
    repeat (99) tick(1'b1);
    chk("t4_stuck_high_time", sh_first, rr + LAT + TMO);
    chk("t4_stuck_low_off", stuck_low, 0);
    repeat (10) tick(1'b0);
    chk("t4_stuck_high_cleared", stuck_high, 0);
    wave(4, 12);
    chk("t4_no_publish", pl_hi.size(), 0);
    wave(4, 12);
    repeat (4) tick(1'b0);
    chk("t4_one_publish", pl_hi.size(), 1);
    if (pl_hi.size() == 1) chk("t4_high", pl_hi[0], 4);

    // 5a. reset pulsed mid-HIGH
    do_reset();
    wave(4, 12);
    repeat (6) tick(1'b1);
    do_reset();
    chk("t5_reset_high_cnt", high_cnt, 0);
    chk("t5_reset_period_cnt", period_cnt, 0);
    wave(4, 12);
    repeat (4) tick(1'b0);
    chk("t5_reset_no_publish", pl_hi.size(), 0);

    // 5b. enable dropped mid-LOW
    wave(4, 12);
    repeat (4) tick(1'b1);
    repeat (6) tick(1'b0);
    chk("t5_pre_high", high_cnt, 4);
    chk("t5_pre_period", period_cnt, 12);
    @(negedge clock);
    enable = 1'b0;
    clear_log();
    repeat (3) tick(1'b0);
    enable = 1'b1;
    wave(4, 12);
    repeat (4) tick(1'b0);
    chk("t5_en_no_publish", pl_hi.size(), 0);
    chk("t5_en_hold_high", high_cnt, 4);
    chk("t5_en_hold_period", period_cnt, 12);

    // 6. single-cycle glitches, P=8
    do_reset();
    for (int i = 0; i < 4; i++) wave(1, 8);
    repeat (4) tick(1'b0);
    chk("t6_pulses", pl_hi.size(), 3);
    for (int i = 0; i < pl_hi.size(); i++) begin
      chk("t6_high", pl_hi[i], 1);
      chk("t6_period", pl_per[i], 8);
    end

    // randomized phase: model comparison every cycle
    do_reset();
    for (int it = 0; it < 250; it++) begin
      int k;
      int w;
      int p;
      k = $urandom_range(0, 24);
      if (k == 0) begin
        do_reset();
      end else if (k == 1) begin
        @(negedge clock);
        enable = 1'b0;
        repeat ($urandom_range(1, 5)) tick(1'($urandom_range(0, 1)));
        enable = 1'b1;
      end else if (k == 2) begin
        repeat ($urandom_range(60, 80)) tick(1'($urandom_range(0, 1) == 1));
      end else if (k == 3) begin
        p = $urandom_range(60, 70);
        repeat (p) tick(1'b1);
      end else if (k == 4) begin
        repeat ($urandom_range(60, 70)) tick(1'b0);
      end else begin
        w = (k == 5) ? $urandom_range(60, 68) : $urandom_range(1, 20);
        p = w + ((k == 6) ? $urandom_range(55, 70) : $urandom_range(1, 30));
        wave(w, p);
      end
    end
    repeat (10) tick(1'b0);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
